// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
// State encoding and the legal pattern-length range live here.
package seq_det_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'b00,
      ST_FILL    = 2'b01,
      ST_ARMED   = 2'b10,
      ST_ILLEGAL = 2'b11
   } seq_state_e;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational pattern comparator for the serial detector.
// Build with SEQDET_MASK_EN defined to add a per-bit don't-care mask.
module seq_match_cmp
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 4
)
(
   input  logic [PAT_W-1:0] word,
   input  logic [PAT_W-1:0] pattern,
`ifdef SEQDET_MASK_EN
   input  logic [PAT_W-1:0] mask,
`endif
   output logic             hit
);

`ifdef SEQDET_MASK_EN
   // A zero mask bit removes that position from the compare.
   assign hit = (((word ^ pattern) & mask) == '0);
`else
   assign hit = (word == pattern);
`endif

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial-pattern detector with run-time overlap select and a saturating match counter.
// Defining SEQDET_MASK_EN adds the pattern_mask input for don't-care positions.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inp,
   input  logic             in_valid,
   input  logic [PAT_W-1:0] pattern,
`ifdef SEQDET_MASK_EN
   input  logic [PAT_W-1:0] pattern_mask,
`endif
   input  logic             overlap,
   input  logic             clear_cnt,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat,
   output logic [1:0]       state
);

   localparam int                FILL_W    = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   seq_state_e        state_r;
   seq_state_e        state_nxt_s;
   logic [PAT_W-2:0]  hist_r;
   logic [PAT_W-2:0]  hist_nxt_s;
   logic [FILL_W-1:0] fill_r;
   logic [FILL_W-1:0] fill_nxt_s;
   logic [FILL_W-1:0] fill_inc_s;
   logic [PAT_W-1:0]  word_s;
   logic              hit_s;
   logic [CNT_W-1:0]  match_cnt_r;
   logic              cnt_sat_r;

   // The completing bit joins the history as the LSB of the compared word.
   assign word_s     = {hist_r, inp};
   assign fill_inc_s = fill_r + FILL_W'(1);

   seq_match_cmp #(.PAT_W(PAT_W)) u_cmp (
      .word    (word_s),
      .pattern (pattern),
`ifdef SEQDET_MASK_EN
      .mask    (pattern_mask),
`endif
      .hit     (hit_s)
   );

   // State, history and fill registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_EMPTY;
         hist_r  <= '0;
         fill_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         hist_r  <= hist_nxt_s;
         fill_r  <= fill_nxt_s;
      end
   end

   // Next-state logic; only accepted bits move the machine.
   always_comb begin
      state_nxt_s = state_r;
      hist_nxt_s  = hist_r;
      fill_nxt_s  = fill_r;
      case (state_r)
         ST_EMPTY: begin
            if (in_valid) begin
               hist_nxt_s  = word_s[PAT_W-2:0];
               fill_nxt_s  = FILL_W'(1);
               state_nxt_s = (PAT_W == 2) ? ST_ARMED : ST_FILL;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FILL: begin
            if (in_valid) begin
               hist_nxt_s  = word_s[PAT_W-2:0];
               fill_nxt_s  = fill_inc_s;
               state_nxt_s = (fill_inc_s == FILL_FULL) ? ST_ARMED : ST_FILL;
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_ARMED: begin
            // Non-overlapping mode consumes the completing bit and restarts.
            if (out && !overlap) begin
               hist_nxt_s  = '0;
               fill_nxt_s  = '0;
               state_nxt_s = ST_EMPTY;
            end else if (in_valid) begin
               hist_nxt_s  = word_s[PAT_W-2:0];
               state_nxt_s = ST_ARMED;
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         default: begin
            hist_nxt_s  = '0;
            fill_nxt_s  = '0;
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // Mealy match pulse, suppressed while reset is held.
   always_comb begin
      out = 1'b0;
      if (!reset && in_valid && (state_r == ST_ARMED) && hit_s) begin
         out = 1'b1;
      end else begin
         out = 1'b0;
      end
   end

   // Saturating match counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clear_cnt) begin
         match_cnt_r <= '0;
         cnt_sat_r   <= 1'b0;
      end else if (out && (match_cnt_r != CNT_MAX)) begin
         match_cnt_r <= match_cnt_r + CNT_W'(1);
         if (match_cnt_r == (CNT_MAX - CNT_W'(1))) begin
            cnt_sat_r <= 1'b1;
         end
      end
   end

   assign match_cnt = match_cnt_r;
   assign cnt_sat   = cnt_sat_r;
   assign state     = state_r;

endmodule
